alu_cmd_ctrl: RTL and testbench
===============================

Name: alu_cmd_ctrl

Overview:
Command front-end feeding the ALU stage. It parses a byte stream from the UART RX path into ALU operations, then drives the ALU's A/B/ALU_FUN/enable inputs. It captures ALU_OUT when OUT_VALID is seen and forwards the result byte to the TX path over a valid/ready handshake. It also holds the last operands so a short command can re-run a new function on them.

Parameters:
DATA_WIDTH, 8, width of RX/TX bytes and of ALU operands/result
FUN_WIDTH, 4, width of ALU function code
TIMEOUT, 15, max cycles to wait for alu_valid before aborting (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous active-high reset
rx_data  in  DATA_WIDTH  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
alu_a  out  DATA_WIDTH  operand A to ALU (registered)
alu_b  out  DATA_WIDTH  operand B to ALU (registered)
alu_fun  out  FUN_WIDTH  function code to ALU (registered)
alu_en  out  1  one-cycle ALU enable (registered)
alu_out  in  DATA_WIDTH  ALU result
alu_valid  in  1  ALU OUT_VALID
tx_data  out  DATA_WIDTH  result byte to TX path
tx_valid  out  1  tx_data valid, held until accepted
tx_ready  in  1  TX path accepts when tx_valid&&tx_ready
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse on ALU timeout

Behaviour:
- Reset (sync, RST=1 at a clock edge): state=IDLE; alu_a=alu_b=0, alu_fun=0, alu_en=0, tx_data=0, tx_valid=0, busy=0, err=0, timeout counter=0. Reset mid-operation aborts everything; any pending tx byte is discarded.
- Commands (first byte, accepted only in IDLE):
  - 0xCC: full op; next three bytes are A, B, FUN.
  - 0xDD: short op; next byte is FUN; reuses held alu_a/alu_b.
  - Any other byte in IDLE: ignored, stay IDLE.
- FUN byte: alu_fun <= rx_data[FUN_WIDTH-1:0]; upper bits ignored.
- States and transitions:
  - IDLE: rx_valid & 0xCC -> GET_A; rx_valid & 0xDD -> GET_FUN.
  - GET_A: on rx_valid, alu_a <= rx_data -> GET_B.
  - GET_B: on rx_valid, alu_b <= rx_data -> GET_FUN.
  - GET_FUN: on rx_valid, alu_fun <= FUN bits -> ALU_RUN.
  - ALU_RUN: exactly one cycle, alu_en=1, counter cleared -> ALU_WAIT. If alu_valid=1 in this cycle, the result is captured and the block goes straight to SEND.
  - ALU_WAIT: alu_en=0. If alu_valid=1, tx_data <= alu_out -> SEND. Otherwise the counter increments; when the counter reaches TIMEOUT with no valid, err pulses 1 cycle -> IDLE, no tx.
  - SEND: tx_valid=1, tx_data stable. When tx_ready=1, tx_valid is 0 the next cycle -> IDLE. There is no bound on how long tx_ready may stay low.
- Timing: alu_en rises the cycle after the FUN byte's rx_valid edge. alu_a/b/fun are stable from that cycle until the next command overwrites them. Operands persist across commands and timeouts.
- rx_valid arriving in ALU_RUN, ALU_WAIT or SEND: byte dropped, no state effect. 0xCC/0xDD seen while in GET_A/GET_B/GET_FUN is treated as data, not as a new command.
- alu_valid outside ALU_RUN/ALU_WAIT: ignored.
- tx_valid never drops without tx_ready. tx_data never changes while tx_valid=1.
- busy is combinational from state (state != IDLE). All other outputs are registered.
- Minimum turnaround: from the FUN byte to tx_valid is 2 cycles when alu_valid is seen in ALU_RUN, 3 when it is seen in the first ALU_WAIT cycle.

Test Plan:
- Full op: RST, then bytes CC,05,03,00; ALU model returns 0x08 with alu_valid 1 cycle after alu_en -> alu_a=05, alu_b=03, alu_fun=0, single alu_en pulse, tx_data=08 with tx_valid until tx_ready, busy returns 0.
- Short op after the full op: bytes DD,01; model returns 0x02 -> alu_a/alu_b still 05/03, alu_fun=1, tx_data=02.
- Backpressure: hold tx_ready=0 for 10 cycles during SEND -> tx_valid and tx_data=08 are held constant; new rx bytes are dropped; 1 cycle after tx_ready=1, tx_valid=0 and the state is IDLE.
- Timeout: CC,01,02,03 with no alu_valid -> err pulses once 15 cycles after entering ALU_WAIT, tx_valid never asserts, block back in IDLE; a following DD,03 completes normally.
- Garbage/CC-as-data: stray byte 0x7F in IDLE is ignored; then CC,CC,DD,04 -> alu_a=CC, alu_b=DD, alu_fun=4.
- Reset mid-op: RST asserted in ALU_WAIT, and separately in SEND with tx_valid=1 -> next cycle all outputs are at reset values and late alu_valid is ignored.

Source files
------------

// File: rtl/alu_cmd_ctrl_if.sv
// Bus bundle between the command front-end and its neighbours:
// UART RX bytes in, ALU operand/enable/result, TX result byte out.
interface alu_cmd_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FUN_WIDTH  = 4
);
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [FUN_WIDTH-1:0]  alu_fun;
   logic                  alu_en;
   logic [DATA_WIDTH-1:0] alu_out;
   logic                  alu_valid;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  busy;
   logic                  err;

   // Controller side
   modport slave (
      input  rx_data, rx_valid, alu_out, alu_valid, tx_ready,
      output alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, err
   );

   // Environment side (RX source, ALU, TX sink)
   modport master (
      output rx_data, rx_valid, alu_out, alu_valid, tx_ready,
      input  alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy, err
   );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ALU command front-end: parses RX bytes into ALU operations, pulses the
// ALU enable, captures the result and hands it to the TX path.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command byte (0xCC full op, 0xDD short op)
// GET_A    | next RX byte is operand A
// GET_B    | next RX byte is operand B
// GET_FUN  | next RX byte carries the function code in its low bits
// ALU_RUN  | alu_en high for this single cycle, result may already arrive
// ALU_WAIT | waiting for alu_valid, bounded by TIMEOUT cycles
// SEND     | tx_valid held with a stable tx_data until tx_ready
module alu_cmd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int FUN_WIDTH  = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic          CLK,
   input  logic          RST,
   alu_cmd_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [DATA_WIDTH-1:0] CMD_FULL  = DATA_WIDTH'('hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_SHORT = DATA_WIDTH'('hDD);

   typedef enum logic [2:0] {
      IDLE,
      GET_A,
      GET_B,
      GET_FUN,
      ALU_RUN,
      ALU_WAIT,
      SEND
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [FUN_WIDTH-1:0]  fun_q, fun_d;
   logic                  en_q, en_d;
   logic [DATA_WIDTH-1:0] txd_q, txd_d;
   logic                  txv_q, txv_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   // State and output registers; reset discards any operation in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         fun_q   <= '0;
         en_q    <= 1'b0;
         txd_q   <= '0;
         txv_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fun_q   <= fun_d;
         en_q    <= en_d;
         txd_q   <= txd_d;
         txv_q   <= txv_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and next-output decode; operands hold unless a byte loads them.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      fun_d   = fun_q;
      en_d    = 1'b0;
      txd_d   = txd_q;
      txv_d   = 1'b0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == CMD_FULL) begin
                  state_d = GET_A;
               end else if (bus.rx_data == CMD_SHORT) begin
                  state_d = GET_FUN;
               end
            end
         end
         GET_A: begin
            if (bus.rx_valid) begin
               a_d     = bus.rx_data;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (bus.rx_valid) begin
               b_d     = bus.rx_data;
               state_d = GET_FUN;
            end
         end
         GET_FUN: begin
            if (bus.rx_valid) begin
               fun_d   = bus.rx_data[FUN_WIDTH-1:0];
               en_d    = 1'b1;
               state_d = ALU_RUN;
            end
         end
         ALU_RUN: begin
            cnt_d = '0;
            if (bus.alu_valid) begin
               txd_d   = bus.alu_out;
               txv_d   = 1'b1;
               state_d = SEND;
            end else begin
               state_d = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            // A result arriving on the last allowed cycle still wins over the timeout.
            if (bus.alu_valid) begin
               txd_d   = bus.alu_out;
               txv_d   = 1'b1;
               state_d = SEND;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SEND: begin
            if (bus.tx_ready) begin
               state_d = IDLE;
            end else begin
               txv_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.alu_a    = a_q;
   assign bus.alu_b    = b_q;
   assign bus.alu_fun  = fun_q;
   assign bus.alu_en   = en_q;
   assign bus.tx_data  = txd_q;
   assign bus.tx_valid = txv_q;
   assign bus.err      = err_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed scenarios plus randomized operations,
// expectations queued at stimulus time and consumed by a monitor.
module tb_alu_cmd_ctrl;

   localparam int DW = 8;
   localparam int FW = 4;
   localparam int TO = 15;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;

   alu_cmd_ctrl_if #(.DATA_WIDTH(DW), .FUN_WIDTH(FW)) bus ();

   alu_cmd_ctrl #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .TIMEOUT(TO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] fun;
      int         c;
   } op_t;
   typedef struct {
      logic [7:0] data;
      int         c;
   } tx_t;

   op_t exp_op[$];
   tx_t exp_tx[$];
   int  exp_err[$];

   int errors = 0;
   int checks = 0;

   logic [7:0] held_a = 8'h00;
   logic [7:0] held_b = 8'h00;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] fun);
      case (fun)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~a;
         default: return a * b;
      endcase
   endfunction

   function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ALU model: answers each alu_en after lat_cfg cycles (negative: never).
   int         lat_cfg = 0;
   logic       m_valid = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] m_out   = 8'h00;
   assign bus.alu_valid = m_valid | s_valid;
   assign bus.alu_out   = m_out;

   initial begin
      forever begin
         @(negedge CLK);
         if (bus.alu_en === 1'b1 && lat_cfg >= 0) begin
            automatic int l = lat_cfg;
            automatic logic [7:0] r = alu_f(bus.alu_a, bus.alu_b, bus.alu_fun);
            if (l == 0) begin
               m_out   = r;
               m_valid = 1'b1;
            end else begin
               repeat (l) @(posedge CLK);
               #1;
               m_out   = r;
               m_valid = 1'b1;
            end
            @(posedge CLK);
            #1;
            m_valid = 1'b0;
            m_out   = 8'($urandom);
         end
      end
   end

   // TX sink: 0 random ready, 1 forced low, 2 forced high.
   int rdy_mode = 0;
   initial begin
      bus.tx_ready = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         case (rdy_mode)
            0:       bus.tx_ready = ($urandom_range(0, 2) != 0);
            1:       bus.tx_ready = 1'b0;
            default: bus.tx_ready = 1'b1;
         endcase
      end
   end

   // Monitor: consumes expectations whenever the DUT presents alu_en, a tx byte or err.
   bit         prev_v   = 1'b0;
   bit         prev_acc = 1'b0;
   bit         prev_en  = 1'b0;
   bit         prev_rst = 1'b1;
   logic [7:0] prev_d   = 8'h00;
   initial begin
      forever begin
         @(negedge CLK);
         if (RST !== 1'b1) begin
            if (!prev_rst) begin
               if (prev_v && !prev_acc) begin
                  chk("tx_valid_hold", 32'(bus.tx_valid), 32'd1);
                  chk("tx_data_hold", 32'(bus.tx_data), 32'(prev_d));
               end
               if (prev_acc) begin
                  chk("tx_valid_drop", 32'(bus.tx_valid), 32'd0);
                  chk("busy_after_accept", 32'(bus.busy), 32'd0);
               end
               if (prev_en) chk("alu_en_single", 32'(bus.alu_en), 32'd0);
            end
            if (bus.alu_en === 1'b1) begin
               if (exp_op.size() == 0) begin
                  chk("spurious_alu_en", 32'(bus.alu_en), 32'd0);
               end else begin
                  automatic op_t o = exp_op.pop_front();
                  chk("alu_a", 32'(bus.alu_a), 32'(o.a));
                  chk("alu_b", 32'(bus.alu_b), 32'(o.b));
                  chk("alu_fun", 32'(bus.alu_fun), 32'(o.fun));
                  chk("alu_en_cycle", 32'(cyc), 32'(o.c));
               end
            end
            if (bus.tx_valid === 1'b1 && !(prev_v && !prev_acc && !prev_rst)) begin
               if (exp_tx.size() == 0) begin
                  chk("spurious_tx_valid", 32'(bus.tx_valid), 32'd0);
               end else begin
                  chk("tx_rise_cycle", 32'(cyc), 32'(exp_tx[0].c));
                  chk("tx_data_rise", 32'(bus.tx_data), 32'(exp_tx[0].data));
               end
            end
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1 && exp_tx.size() != 0) begin
               automatic tx_t t = exp_tx.pop_front();
               chk("tx_data_accept", 32'(bus.tx_data), 32'(t.data));
            end
            if (bus.err === 1'b1) begin
               if (exp_err.size() == 0) chk("spurious_err", 32'(bus.err), 32'd0);
               else chk("err_cycle", 32'(cyc), 32'(exp_err.pop_front()));
            end
         end
         prev_v   = (bus.tx_valid === 1'b1);
         prev_acc = (bus.tx_valid === 1'b1) && (bus.tx_ready === 1'b1);
         prev_d   = bus.tx_data;
         prev_en  = (bus.alu_en === 1'b1);
         prev_rst = (RST === 1'b1);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick();
   endtask

   // Sends one command and queues what the block must do in response.
   task automatic issue(input bit full, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] f, input int lat);
      int c;
      if (full) begin
         send(8'hCC);
         send(a);
         send(b);
         held_a = a;
         held_b = b;
      end else begin
         send(8'hDD);
      end
      lat_cfg = (lat > TO) ? -1 : lat;
      c = cyc;
      exp_op.push_back('{held_a, held_b, f[3:0], c + 1});
      if (lat >= 0 && lat <= TO) exp_tx.push_back('{alu_f(held_a, held_b, f[3:0]), c + 2 + lat});
      else exp_err.push_back(c + TO + 2);
      bus.rx_data  = f;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus.busy === 1'b0 && exp_op.size() == 0 && exp_tx.size() == 0 &&
             exp_err.size() == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_tx(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.tx_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   task automatic do_op(input bit full, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] f, input int lat);
      issue(full, a, b, f, lat);
      wait_idle("op_complete");
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      exp_op.delete();
      exp_tx.delete();
      exp_err.delete();
      held_a = 8'h00;
      held_b = 8'h00;
      tick();
      RST = 1'b0;
      chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
      chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
      chk("rst_alu_fun", 32'(bus.alu_fun), 32'd0);
      chk("rst_alu_en", 32'(bus.alu_en), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      RST          = 1'b1;
      repeat (3) tick();
      apply_reset();
      repeat (2) tick();

      // Basic full and short operations
      do_op(1'b1, 8'h05, 8'h03, 8'h00, 1);
      do_op(1'b0, 8'h00, 8'h00, 8'h01, 2);
      chk("held_a_after_short", 32'(bus.alu_a), 32'h05);
      chk("held_b_after_short", 32'(bus.alu_b), 32'h03);

      // Backpressure with bytes arriving during SEND
      rdy_mode = 1;
      issue(1'b1, 8'h05, 8'h03, 8'h00, 0);
      wait_tx("bp_send_reached");
      for (int i = 0; i < 10; i++) begin
         bus.rx_data  = (i == 0) ? 8'hCC : 8'($urandom);
         bus.rx_valid = 1'b1;
         tick();
      end
      bus.rx_valid = 1'b0;
      chk("bp_tx_data_held", 32'(bus.tx_data), 32'h08);
      rdy_mode = 2;
      wait_idle("bp_complete");
      rdy_mode = 0;

      // Timeout, then a short op on the same operands
      do_op(1'b1, 8'h01, 8'h02, 8'h03, -1);
      do_op(1'b0, 8'h00, 8'h00, 8'h03, 0);

      // Stray byte in IDLE, then command bytes used as data
      send(8'h7F);
      chk("stray_byte_ignored", 32'(bus.busy), 32'd0);
      do_op(1'b1, 8'hCC, 8'hDD, 8'h04, 2);

      // Result on the last allowed wait cycle, and one cycle too late
      do_op(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), TO);
      do_op(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), TO + 1);

      // Randomized operations
      for (int n = 0; n < 40; n++) begin
         automatic int lat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 17))
                                                         : int'($urandom_range(0, 4));
         do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), lat);
      end

      // Reset while waiting for the ALU; the late result must be ignored
      issue(1'b1, 8'h11, 8'h22, 8'h01, 12);
      repeat (4) tick();
      chk("busy_in_wait", 32'(bus.busy), 32'd1);
      apply_reset();
      repeat (20) tick();
      chk("late_valid_ignored", 32'(bus.tx_valid), 32'd0);

      // Reset while a byte is pending in SEND
      rdy_mode = 1;
      issue(1'b1, 8'h33, 8'h44, 8'h00, 0);
      wait_tx("rst_send_reached");
      tick();
      apply_reset();
      rdy_mode = 0;

      // alu_valid while IDLE is ignored
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      repeat (5) tick();
      chk("idle_valid_busy", 32'(bus.busy), 32'd0);
      chk("idle_valid_tx", 32'(bus.tx_valid), 32'd0);

      // Operands cleared by reset feed the next short op
      do_op(1'b0, 8'h00, 8'h00, 8'h00, 1);

      repeat (3) tick();
      chk("queues_drained", 32'(exp_op.size() + exp_tx.size() + exp_err.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
